// File: rtl/tick_period_meter_pkg.sv
// Shared types and default width for the tick period meter.
package tick_period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        MEASURE
    } tpm_state_t;

    localparam int TPM_N = 27;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear and load-to-one, used as the interval timer.
module sat_counter #(
    parameter int N = 27
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load_one,
    input  logic         inc,
    output logic [N-1:0] count,
    output logic         at_max
);

    assign at_max = &count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load_one) begin
            count <= N'(1);
        end else if (inc && !at_max) begin
            count <= count + N'(1);
        end
    end

endmodule

// File: rtl/tick_period_meter.sv
// Measures clk cycles between consecutive tic strobes and offers each period on valid/ready.
// Optional min/max tracking is built when TICK_PERIOD_METER_MINMAX_EN is defined.
module tick_period_meter
    import tick_period_meter_pkg::*;
#(
    parameter int N = TPM_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         tic,
    input  logic         out_ready,
    output logic [N-1:0] period,
    output logic         period_valid,
    output logic         period_ovf,
    output logic         missed,
    output logic         locked
`ifdef TICK_PERIOD_METER_MINMAX_EN
    ,
    output logic [N-1:0] per_min,
    output logic [N-1:0] per_max
`endif
);

    tpm_state_t   state;
    tpm_state_t   state_next;
    logic         cnt_clr;
    logic         cnt_load;
    logic         cnt_inc;
    logic         capture;
    logic [N-1:0] count;
    logic         at_max;
    logic         ovf_flag;

    sat_counter #(.N(N)) u_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load_one (cnt_load),
        .inc      (cnt_inc),
        .count    (count),
        .at_max   (at_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A low en overrides everything, including a tic in the same cycle.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        capture    = 1'b0;
        if (!en) begin
            state_next = IDLE;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt_clr    = 1'b1;
                    state_next = WAIT_FIRST;
                end
                WAIT_FIRST: begin
                    if (tic) begin
                        cnt_load   = 1'b1;
                        state_next = MEASURE;
                    end
                end
                MEASURE: begin
                    if (tic) begin
                        capture  = 1'b1;
                        cnt_load = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Overflow only when the interval exceeds the max count, so exactly 2^N-1 is still exact.
    always_ff @(posedge clk) begin
        if (rst || !en || cnt_load) begin
            ovf_flag <= 1'b0;
        end else if (cnt_inc && at_max) begin
            ovf_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period       <= '0;
            period_valid <= 1'b0;
            period_ovf   <= 1'b0;
            missed       <= 1'b0;
            locked       <= 1'b0;
        end else begin
            if (capture && (!period_valid || out_ready)) begin
                period       <= count;
                period_ovf   <= ovf_flag;
                period_valid <= 1'b1;
            end else begin
                if (capture) begin
                    missed <= 1'b1;
                end
                if (period_valid && out_ready) begin
                    period_valid <= 1'b0;
                end
            end
            if (!en) begin
                locked <= 1'b0;
            end else if (capture) begin
                locked <= 1'b1;
            end
        end
    end

`ifdef TICK_PERIOD_METER_MINMAX_EN
    logic en_prev;

    // Extremes track every capture, including ones dropped by backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_prev <= 1'b0;
            per_min <= '1;
            per_max <= '0;
        end else begin
            en_prev <= en;
            if (en && !en_prev) begin
                per_min <= '1;
                per_max <= '0;
            end else if (capture) begin
                if (count < per_min) per_min <= count;
                if (count > per_max) per_max <= count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter at N=8; min/max checks run when TICK_PERIOD_METER_MINMAX_EN is defined.
module tb_tick_period_meter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         tic;
    logic         out_ready;
    logic [N-1:0] period;
    logic         period_valid;
    logic         period_ovf;
    logic         missed;
    logic         locked;
`ifdef TICK_PERIOD_METER_MINMAX_EN
    logic [N-1:0] per_min;
    logic [N-1:0] per_max;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    tick_period_meter #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .tic          (tic),
        .out_ready    (out_ready),
        .period       (period),
        .period_valid (period_valid),
        .period_ovf   (period_ovf),
        .missed       (missed),
        .locked       (locked)
`ifdef TICK_PERIOD_METER_MINMAX_EN
        ,
        .per_min      (per_min),
        .per_max      (per_max)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        tic = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic tic1();
        tic = 1'b1;
        tick();
        tic = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; tic = 1'b0; out_ready = 1'b1;
        // Reset held two cycles with tic pulsing
        tic = 1'b1; tick();
        tic = 1'b0; tick();
        chk("rst_period", 32'(period), 0);
        chk("rst_valid", 32'(period_valid), 0);
        chk("rst_ovf", 32'(period_ovf), 0);
        chk("rst_missed", 32'(missed), 0);
        chk("rst_locked", 32'(locked), 0);

        rst = 1'b0;
        tick();
        tic1();
        chk("first_tic_no_result", 32'(period_valid), 0);
        chk("first_tic_unlocked", 32'(locked), 0);

        idle(4); tic1();
        chk("p5_valid", 32'(period_valid), 1);
        chk("p5_value", 32'(period), 5);
        chk("p5_ovf", 32'(period_ovf), 0);
        chk("p5_locked", 32'(locked), 1);
        idle(1);
        chk("p5_accepted", 32'(period_valid), 0);
        idle(8); tic1();
        chk("p10_value", 32'(period), 10);
        chk("p10_valid", 32'(period_valid), 1);

        // Saturation boundaries
        idle(254); tic1();
        chk("p255_value", 32'(period), 255);
        chk("p255_ovf", 32'(period_ovf), 0);
        idle(299); tic1();
        chk("p300_value", 32'(period), 255);
        chk("p300_ovf", 32'(period_ovf), 1);
        idle(3); tic1();
        chk("p4_value", 32'(period), 4);
        chk("p4_ovf", 32'(period_ovf), 0);

        // Backpressure
        en = 1'b0; tick();
        chk("flush_valid", 32'(period_valid), 0);
        en = 1'b1; tick();
        out_ready = 1'b0;
        tic1();
        idle(2); tic1();
        chk("bp_first_value", 32'(period), 3);
        chk("bp_first_valid", 32'(period_valid), 1);
        chk("bp_no_missed_yet", 32'(missed), 0);
        idle(2);
        chk("bp_hold_value", 32'(period), 3);
        tic1();
        chk("bp_drop_value", 32'(period), 3);
        chk("bp_drop_missed", 32'(missed), 1);
        idle(4);
        out_ready = 1'b1;
        tic1();
        out_ready = 1'b0;
        chk("bp_reload_value", 32'(period), 5);
        chk("bp_reload_valid", 32'(period_valid), 1);
        chk("bp_missed_sticky", 32'(missed), 1);

        // en dropped with a result pending
        idle(2);
        en = 1'b0; tick();
        chk("endrop_locked", 32'(locked), 0);
        chk("endrop_valid", 32'(period_valid), 1);
        chk("endrop_value", 32'(period), 5);
        tic1();
        chk("endrop_tic_ignored", 32'(period), 5);
        out_ready = 1'b1; tick();
        chk("endrop_accepted", 32'(period_valid), 0);
        en = 1'b1; tick();
        idle(5);
        tic1();
        chk("reen_first_tic_no_result", 32'(period_valid), 0);
        idle(5); tic1();
        chk("reen_value", 32'(period), 6);
        chk("reen_locked", 32'(locked), 1);

`ifdef TICK_PERIOD_METER_MINMAX_EN
        en = 1'b0; tick();
        en = 1'b1; tick();
        chk("mm_init_min", 32'(per_min), 255);
        chk("mm_init_max", 32'(per_max), 0);
        tic1();
        idle(6); tic1();
        idle(2); tic1();
        idle(11); tic1();
        chk("mm_min", 32'(per_min), 3);
        chk("mm_max", 32'(per_max), 12);
        en = 1'b0; tick();
        en = 1'b1; tick();
        chk("mm_reinit_min", 32'(per_min), 255);
        chk("mm_reinit_max", 32'(per_max), 0);
`endif

        rst = 1'b1; tick();
        rst = 1'b0;
        chk("final_rst_missed", 32'(missed), 0);
        chk("final_rst_valid", 32'(period_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
